load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port: clk  in  1  single clock; every flop is updated on its rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, synchronous and active-low.
REQ-003 SHALL have port: issue  in  1  start a memory operation; sampled only in IDLE.
REQ-004 SHALL have port: instruction  in  32  opcode [6:0] and funct3 [14:12], both latched on an accepted issue.
REQ-005 SHALL have port: addr  in  32  byte address from the ALU, latched on an accepted issue.
REQ-006 SHALL have port: store_data  in  32  rs2 value, latched on an accepted issue.
REQ-007 SHALL have port: busy  out  1  high whenever state is not IDLE.
REQ-008 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-009 SHALL have port: load_data  out  32  selected lane right-aligned to bit 0, for writeback sign/zero extension.
REQ-010 SHALL have port: dmem_req  out  1  memory request.
REQ-011 SHALL have port: dmem_we  out  4  byte write enables.
REQ-012 SHALL have port: dmem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-013 SHALL have port: dmem_wdata  out  32  lane-replicated store data.
REQ-014 SHALL have port: dmem_ack  in  1  memory completion.
REQ-015 SHALL have port: dmem_rdata  in  32  read word, valid when dmem_ack is high.
REQ-016 SHALL have port: misalign  out  1  misalignment flag; exists under REQ-031 only.

Function
REQ-017 SHALL implement states IDLE, BUSY and DONE.
REQ-018 SHALL move IDLE->BUSY on issue with OPC_LOAD/OPC_STORE; any other opcode SHALL go IDLE->DONE with no memory access.
REQ-019 SHALL hold dmem_req=1, dmem_addr, dmem_we and dmem_wdata stable throughout BUSY; all are 0 outside BUSY.
REQ-020 SHALL go BUSY->DONE on the edge where dmem_ack=1; the ack may arrive in the first BUSY cycle.
REQ-021 SHALL assert done for exactly the DONE cycle, then return to IDLE; minimum issue-to-done latency is 2 cycles.
REQ-022 SHALL ignore issue outside IDLE and dmem_ack outside BUSY.
REQ-023 SHALL set dmem_we for stores as: SW 4'b1111; SH 4'b0011<<(2*addr[1]); SB 4'b0001<<addr[1:0]; loads 4'b0000.
REQ-024 SHALL drive dmem_wdata as: SB byte replicated x4; SH halfword replicated x2; SW unchanged.
REQ-025 SHALL capture load_data on the ack edge as: LB/LBU rdata>>(8*addr[1:0]); LH/LHU rdata>>(16*addr[1]); LW unchanged.
REQ-026 SHALL hold load_data until the next load capture; stores SHALL NOT change it.

Reset
REQ-027 SHALL, while rst_n=0 at an edge, force state IDLE, done=0, busy=0, load_data=0 and misalign=0.
REQ-028 SHALL abort an in-flight operation when reset occurs mid-BUSY: dmem_req=0 from the next cycle and no done pulse.
REQ-029 SHALL ignore a late dmem_ack that follows reset.

Configuration
REQ-030 SHALL use macro MISALIGN_TRAP_EN.
REQ-031 SHALL, when MISALIGN_TRAP_EN is defined, treat LW/SW with addr[1:0]!=0 and LH/LHU/SH with addr[0]!=0 as misaligned: go IDLE->DONE with no request, pulse misalign with done, and leave load_data unchanged.
REQ-032 SHALL, when MISALIGN_TRAP_EN is undefined, omit the misalign port and ignore the excess low address bits (word: addr[1:0]; half: addr[0]).

Verification
REQ-033 SHALL cover: LW addr=0x104, ack 3 cycles after req, rdata=0xDEADBEEF -> load_data=0xDEADBEEF, done 1 cycle after ack, busy for 4 cycles.
REQ-034 SHALL cover: LBU addr=0x103, rdata=0x8A000000, same-cycle ack -> load_data=0x0000008A, done 2 cycles after issue.
REQ-035 SHALL cover: SH addr=0x202, store_data=0x1234ABCD -> dmem_we=4'b1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200.
REQ-036 SHALL cover: rst_n=0 mid-BUSY, then ack=1 one cycle later -> no done pulse, state IDLE, dmem_req=0.
REQ-037 SHALL cover: SW addr=0x301 with MISALIGN_TRAP_EN -> no dmem_req, misalign=1 and done=1 in the same cycle; without the macro -> dmem_we=4'b1111, dmem_addr=0x300.
REQ-038 SHALL cover: issue held high during BUSY, and ADD opcode issued -> extra issues ignored; ADD gives done next cycle with dmem_req never asserted.

Source files
------------

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Sequences one data-memory access per issued load/store instruction.
//   The FSM runs IDLE -> BUSY -> DONE -> IDLE for loads/stores.
//   Any other opcode (and, when trapping is enabled, a misaligned access)
//   goes straight from IDLE to DONE without touching memory.
//
//   Configuration macro: MISALIGN_TRAP_EN
//     defined   : misaligned LW/SW/LH/LHU/SH are trapped and reported on
//                 the misalign port.
//     undefined : the misalign port is absent. Excess low address bits are
//                 ignored.
//
//   Handshake: dmem_req and its qualifiers (dmem_addr, dmem_we, dmem_wdata)
//   rise together on the edge that accepts the issue. They stay stable for
//   the whole of BUSY. The access completes on the first rising edge that
//   samples dmem_ack=1 while in BUSY, and then every request output drops
//   to 0. dmem_ack seen in any other state has no effect.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   issue                 start request; sampled only in IDLE
//   instruction           opcode [6:0] and funct3 [14:12] are used
//   addr, store_data      ALU byte address and rs2 value
//   busy, done            state != IDLE; one-cycle completion pulse
//   load_data             loaded lane right-aligned to bit 0
//   dmem_*                data-memory request/response
//   misalign              trap flag, pulses with done (MISALIGN_TRAP_EN only)
//   dbg_state_o           current FSM state, for observation
// -----------------------------------------------------------------------------
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue,
    input  logic [31:0] instruction,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        dmem_req,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic [1:0]  dbg_state_o
);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic        done_q;
    logic [31:0] load_data_q;
    logic        req_q;
    logic [3:0]  we_q;
    logic [31:0] daddr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        is_load_q;

    // Decode of the instruction currently presented at the issue port
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_load;
    logic        is_store;
    logic        mis_c;
    logic [3:0]  we_c;
    logic [31:0] wdata_c;
    logic [31:0] lane_c;

    // Only opcode and funct3 matter to this unit
    logic        unused_instr_bits;
    assign unused_instr_bits = ^{instruction[31:15], instruction[11:7]};

    assign opcode   = instruction[6:0];
    assign funct3   = instruction[14:12];
    assign is_load  = (opcode == OPC_LOAD);
    assign is_store = (opcode == OPC_STORE);

    always_comb begin
        we_c    = 4'b0000;
        wdata_c = 32'd0;
        if (is_store) begin
            case (funct3)
                3'b000: begin
                    we_c    = 4'b0001 << addr[1:0];
                    wdata_c = {4{store_data[7:0]}};
                end
                3'b001: begin
                    we_c    = 4'b0011 << {addr[1], 1'b0};
                    wdata_c = {2{store_data[15:0]}};
                end
                default: begin
                    we_c    = 4'b1111;
                    wdata_c = store_data;
                end
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;
    // funct3[1:0] = 10 is a word access, and 01 is a halfword access (signed or unsigned)
    always_comb begin
        mis_c = 1'b0;
        if (is_load || is_store) begin
            if (funct3[1:0] == 2'b10)
                mis_c = (addr[1:0] != 2'b00);
            else if (funct3[1:0] == 2'b01)
                mis_c = addr[0];
        end
    end
    assign misalign = misalign_q;
`else
    assign mis_c = 1'b0;
`endif

    // Lane extraction from the returning word, using the latched funct3/offset
    always_comb begin
        case (funct3_q)
            3'b000, 3'b100: lane_c = dmem_rdata >> {off_q, 3'b000};
            3'b001, 3'b101: lane_c = dmem_rdata >> {off_q[1], 4'b0000};
            default:        lane_c = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            load_data_q <= 32'd0;
            req_q       <= 1'b0;
            we_q        <= 4'b0000;
            daddr_q     <= 32'd0;
            wdata_q     <= 32'd0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            is_load_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        funct3_q  <= funct3;
                        off_q     <= addr[1:0];
                        is_load_q <= is_load;
                        if ((is_load || is_store) && !mis_c) begin
                            state_q <= S_BUSY;
                            req_q   <= 1'b1;
                            we_q    <= we_c;
                            daddr_q <= {addr[31:2], 2'b00};
                            wdata_q <= wdata_c;
                        end else begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                            misalign_q <= mis_c;
`endif
                        end
                    end
                end
                S_BUSY: begin
                    if (dmem_ack) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        req_q   <= 1'b0;
                        we_q    <= 4'b0000;
                        daddr_q <= 32'd0;
                        wdata_q <= 32'd0;
                        if (is_load_q)
                            load_data_q <= lane_c;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    done_q     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                    misalign_q <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign load_data   = load_data_q;
    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = daddr_q;
    assign dmem_wdata  = wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue;
    logic [31:0] instruction;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        dmem_req;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [1:0]  dbg_state;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    load_store_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue       (issue),
        .instruction (instruction),
        .addr        (addr),
        .store_data  (store_data),
        .busy        (busy),
        .done        (done),
        .load_data   (load_data),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
`ifdef MISALIGN_TRAP_EN
        .misalign    (misalign),
`endif
        .dbg_state_o (dbg_state)
    );

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          delay;     // BUSY cycles before the ack cycle
        logic        mem;       // expect a memory request
        logic        is_store;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [31:0] daddr;
        logic [31:0] ld;        // load_data after completion
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] ins(input logic [2:0] f3, input logic [6:0] op);
        return {17'd0, f3, 5'd0, op};
    endfunction

    function automatic vec_t mk(input string nm, input logic [31:0] i, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rd, input int dl,
                                input logic m, input logic st, input logic [3:0] we,
                                input logic [31:0] wd, input logic [31:0] da, input logic [31:0] ld);
        vec_t v;
        v.name = nm; v.instr = i; v.addr = a; v.sdata = sd; v.rdata = rd; v.delay = dl;
        v.mem = m; v.is_store = st; v.we = we; v.wdata = wd; v.daddr = da; v.ld = ld;
        return v;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_vec(input vec_t v);
        int busy_cycles;
        busy_cycles = 0;
        @(negedge clk);
        issue = 1'b1; instruction = v.instr; addr = v.addr; store_data = v.sdata;
        @(negedge clk);
        issue = 1'b0; instruction = $urandom; addr = $urandom; store_data = $urandom;
        if (busy) busy_cycles++;
        if (v.mem) begin
            chk({v.name, " req"}, dmem_req, 1);
            chk({v.name, " we"}, dmem_we, v.we);
            chk({v.name, " daddr"}, dmem_addr, v.daddr);
            if (v.is_store) chk({v.name, " wdata"}, dmem_wdata, v.wdata);
            for (int i = 0; i < v.delay; i++) begin
                @(negedge clk);
                if (busy) busy_cycles++;
                chk({v.name, " req held"}, {dmem_req, dmem_we, dmem_addr}, {1'b1, v.we, v.daddr});
            end
            dmem_ack = 1'b1; dmem_rdata = v.rdata;
            @(negedge clk);
            dmem_ack = 1'b0; dmem_rdata = $urandom;
            if (busy) busy_cycles++;
            chk({v.name, " req drop"}, dmem_req, 0);
        end else begin
            chk({v.name, " no req"}, dmem_req, 0);
        end
        chk({v.name, " done"}, done, 1);
        chk({v.name, " load_data"}, load_data, v.ld);
`ifdef MISALIGN_TRAP_EN
        chk({v.name, " misalign"}, misalign, 0);
`endif
        @(negedge clk);
        chk({v.name, " done low"}, done, 0);
        chk({v.name, " idle"}, {busy, dbg_state}, 3'b000);
        chk({v.name, " busy cycles"}, busy_cycles, v.mem ? v.delay + 2 : 1);
    endtask

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] AL = 7'b0110011;

    initial begin
        int dones;
        int reqs;
        rst_n = 1'b0; issue = 1'b0; instruction = '0; addr = '0; store_data = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;

        vecs.push_back(mk("LW",   ins(3'b010, LD), 32'h104, 0, 32'hDEADBEEF, 2, 1, 0, 4'b0000, 0, 32'h104, 32'hDEADBEEF));
        vecs.push_back(mk("LBU",  ins(3'b100, LD), 32'h103, 0, 32'h8A000000, 0, 1, 0, 4'b0000, 0, 32'h100, 32'h0000008A));
        vecs.push_back(mk("LB1",  ins(3'b000, LD), 32'h101, 0, 32'h0000C300, 1, 1, 0, 4'b0000, 0, 32'h100, 32'h000000C3));
        vecs.push_back(mk("LH2",  ins(3'b001, LD), 32'h102, 0, 32'hBEEF0000, 0, 1, 0, 4'b0000, 0, 32'h100, 32'h0000BEEF));
        vecs.push_back(mk("LHU0", ins(3'b101, LD), 32'h100, 0, 32'h00005678, 1, 1, 0, 4'b0000, 0, 32'h100, 32'h00005678));
        vecs.push_back(mk("SH",   ins(3'b001, ST), 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 0, 1, 1, 4'b1100, 32'hABCDABCD, 32'h200, 32'h00005678));
        vecs.push_back(mk("SB1",  ins(3'b000, ST), 32'h201, 32'h000000A5, 32'h11111111, 1, 1, 1, 4'b0010, 32'hA5A5A5A5, 32'h200, 32'h00005678));
        vecs.push_back(mk("SB3",  ins(3'b000, ST), 32'h203, 32'h12345677, 32'h0, 0, 1, 1, 4'b1000, 32'h77777777, 32'h200, 32'h00005678));
        vecs.push_back(mk("SH0",  ins(3'b001, ST), 32'h200, 32'hFFFF0042, 32'h0, 0, 1, 1, 4'b0011, 32'h00420042, 32'h200, 32'h00005678));
        vecs.push_back(mk("SW",   ins(3'b010, ST), 32'h300, 32'hCAFEF00D, 32'h0, 2, 1, 1, 4'b1111, 32'hCAFEF00D, 32'h300, 32'h00005678));
        vecs.push_back(mk("ADD",  ins(3'b000, AL), 32'h104, 32'h5, 32'h0, 0, 0, 0, 4'b0000, 0, 32'h0, 32'h00005678));
        vecs.push_back(mk("LBU2", ins(3'b100, LD), 32'h102, 0, 32'h00990000, 0, 1, 0, 4'b0000, 0, 32'h100, 32'h00000099));
`ifndef MISALIGN_TRAP_EN
        vecs.push_back(mk("SWmis", ins(3'b010, ST), 32'h301, 32'h01020304, 32'h0, 0, 1, 1, 4'b1111, 32'h01020304, 32'h300, 32'h00000099));
        vecs.push_back(mk("LWmis", ins(3'b010, LD), 32'h107, 0, 32'h13572468, 1, 1, 0, 4'b0000, 0, 32'h104, 32'h13572468));
`endif

        // reset state
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset load_data", load_data, 0);
        chk("reset req", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, 0);
        chk("reset state", dbg_state, 0);
`ifdef MISALIGN_TRAP_EN
        chk("reset misalign", misalign, 0);
`endif
        rst_n = 1'b1;

        // ack while idle is ignored
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("idle ack", {busy, done, load_data}, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // issue held high during BUSY: exactly one operation
        dones = 0; reqs = 0;
        @(negedge clk);
        issue = 1'b1; instruction = ins(3'b010, LD); addr = 32'h400;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (dmem_req) reqs++;
            instruction = ins(3'b000, ST); addr = 32'h500;
        end
        chk("held issue daddr", dmem_addr, 32'h400);
        chk("held issue we", dmem_we, 4'b0000);
        dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
        @(negedge clk);
        dmem_ack = 1'b0; issue = 1'b0;
        if (done) dones++;
        chk("held issue load_data", load_data, 32'h0BADF00D);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (dmem_req) reqs++;
        end
        chk("held issue dones", dones, 1);
        chk("held issue req cycles", reqs, 3);
        chk("held issue idle", busy, 0);

        // ADD: done the next cycle, never a request
        @(negedge clk);
        issue = 1'b1; instruction = ins(3'b000, AL); addr = 32'h104;
        @(negedge clk);
        issue = 1'b0;
        chk("ADD done", {done, busy, dmem_req}, 3'b110);
        @(negedge clk);
        chk("ADD after", {done, busy, dmem_req}, 3'b000);

        // reset mid-BUSY, then a late ack
        @(negedge clk);
        issue = 1'b1; instruction = ins(3'b010, LD); addr = 32'h104;
        @(negedge clk);
        issue = 1'b0;
        chk("abort req", dmem_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h55555555;
        chk("abort req drop", {dmem_req, busy, done}, 3'b000);
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("abort late ack", {dmem_req, busy, done}, 3'b000);
        chk("abort load_data", load_data, 0);
        chk("abort state", dbg_state, 0);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort no done", dones, 0);

`ifdef MISALIGN_TRAP_EN
        // misaligned SW traps without a request
        @(negedge clk);
        issue = 1'b1; instruction = ins(3'b010, ST); addr = 32'h301; store_data = 32'h01020304;
        @(negedge clk);
        issue = 1'b0;
        chk("SW mis trap", {dmem_req, misalign, done}, 3'b011);
        @(negedge clk);
        chk("SW mis after", {dmem_req, misalign, done, busy}, 4'b0000);
        // misaligned LH leaves load_data unchanged (0 after abort)
        issue = 1'b1; instruction = ins(3'b001, LD); addr = 32'h101;
        @(negedge clk);
        issue = 1'b0;
        chk("LH mis trap", {dmem_req, misalign, done}, 3'b011);
        chk("LH mis load_data", load_data, 0);
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
